// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: field widths, special encodings, FSM and operand-class enums.
// Also holds the leading-zero counter used to normalize subnormal operands.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    RND
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    SUB,
    NORM,
    INF,
    NAN
  } fp_class_t;

  // Priority encoder: shift needed to bring the leading one up to bit 10.
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      if (v[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp16_div_seq_if.sv
// Start/done handshake bundle of the sequential FP16 divider.
// The slave modport is the divider side, the master modport the issuing side.
interface fp16_div_seq_if;
  import fp16_pkg::*;

  logic        i_start;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_result;
  logic        o_overflow;
  logic        o_underflow;
  logic        o_div_by_zero;
  logic        o_invalid;
  logic        o_inexact;

  modport slave (
    input  i_start, i_a, i_b,
    output o_busy, o_done, o_result,
           o_overflow, o_underflow, o_div_by_zero, o_invalid, o_inexact
  );

  modport master (
    output i_start, i_a, i_b,
    input  o_busy, o_done, o_result,
           o_overflow, o_underflow, o_div_by_zero, o_invalid, o_inexact
  );

endinterface

// File: rtl/fp16_unpack.sv
// Combinational FP16 operand decoder: class, normalized 11-bit mantissa and signed
// effective exponent (subnormals shifted left by their leading-zero count).
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [14:0]        i_x,
  output fp_class_t          o_cls,
  output logic [10:0]        o_mant,
  output logic signed [6:0]  o_exp
);

  logic [EXP_W-1:0]  w_e;
  logic [FRAC_W-1:0] w_f;
  logic [3:0]        w_lz;

  assign w_e  = i_x[14:10];
  assign w_f  = i_x[9:0];
  assign w_lz = lzc11({1'b0, w_f});

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    o_cls  = NORM;
    o_mant = {1'b1, w_f};
    o_exp  = $signed({2'b00, w_e});
    if (w_e == '1) begin
      o_cls = (w_f != '0) ? NAN : INF;
    end else if (w_e == '0) begin
      if (w_f == '0) begin
        o_cls  = ZERO;
        o_mant = '0;
        o_exp  = '0;
      end else begin
        o_cls  = SUB;
        o_mant = {1'b0, w_f} << w_lz;
        o_exp  = 7'sd1 - $signed({3'b000, w_lz});
      end
    end
  end

endmodule

// File: rtl/fp16_div_seq.sv
// Sequential FP16 divider: restoring shift-subtract loop, one quotient bit per cycle,
// round-half-up, subnormal results flushed to zero.
module fp16_div_seq
  import fp16_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fp16_div_seq_if.slave bus
);

  localparam logic signed [6:0] BIAS_Q = 7'(BIAS);

  state_t             r_state;
  logic               r_sign;
  logic signed [6:0]  r_exp;
  logic [11:0]        r_rem;
  logic [10:0]        r_mb;
  logic [12:0]        r_q;
  logic [3:0]         r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [15:0]        r_result;
  logic               r_ovf;
  logic               r_unf;
  logic               r_dbz;
  logic               r_inv;
  logic               r_inx;

  fp_class_t          w_cls_a;
  fp_class_t          w_cls_b;
  logic [10:0]        w_mant_a;
  logic [10:0]        w_mant_b;
  logic signed [6:0]  w_exp_a;
  logic signed [6:0]  w_exp_b;
  logic               w_sign;

  fp16_unpack u_unpack_a (
    .i_x    (bus.i_a[14:0]),
    .o_cls  (w_cls_a),
    .o_mant (w_mant_a),
    .o_exp  (w_exp_a)
  );

  fp16_unpack u_unpack_b (
    .i_x    (bus.i_b[14:0]),
    .o_cls  (w_cls_b),
    .o_mant (w_mant_b),
    .o_exp  (w_exp_b)
  );

  assign w_sign = bus.i_a[15] ^ bus.i_b[15];

  logic        w_special;
  logic        w_spec_inv;
  logic        w_spec_dbz;
  logic [15:0] w_spec_res;

  always_comb begin
    w_special  = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_dbz = 1'b0;
    w_spec_res = {w_sign, 15'h0000};
    if (w_cls_a == NAN || w_cls_b == NAN ||
        (w_cls_a == ZERO && w_cls_b == ZERO) ||
        (w_cls_a == INF && w_cls_b == INF)) begin
      w_spec_inv = 1'b1;
      w_spec_res = QNAN;
    end else if (w_cls_a == INF) begin
      w_spec_res = {w_sign, POS_INF[14:0]};
    end else if (w_cls_b == ZERO) begin
      w_spec_dbz = 1'b1;
      w_spec_res = {w_sign, POS_INF[14:0]};
    end else if (w_cls_a == ZERO || w_cls_b == INF) begin
      w_spec_res = {w_sign, 15'h0000};
    end else begin
      w_special = 1'b0;
    end
  end

  // Remainder stays below 2*m_b, so after a subtract it fits in 11 bits.
  logic        w_ge;
  logic [10:0] w_diff;
  logic [11:0] w_rem_nxt;

  assign w_ge      = r_rem >= {1'b0, r_mb};
  assign w_diff    = r_rem[10:0] - r_mb;
  assign w_rem_nxt = w_ge ? {w_diff, 1'b0} : {r_rem[10:0], 1'b0};

  logic [9:0]        w_frac;
  logic [9:0]        w_frac_rnd;
  logic              w_rbit;
  logic              w_sticky;
  logic              w_carry;
  logic signed [6:0] w_exp_n;
  logic signed [6:0] w_exp_fin;
  logic              w_ovf;
  logic              w_unf;

  // The hidden one is implicit; an all-ones fraction rounding up wraps to 0 and bumps the exponent.
  assign w_frac     = r_q[12] ? r_q[11:2] : r_q[10:1];
  assign w_rbit     = r_q[12] ? r_q[1] : r_q[0];
  assign w_sticky   = (r_q[12] & r_q[0]) | (r_rem != '0);
  assign w_exp_n    = r_q[12] ? r_exp : r_exp - 7'sd1;
  assign w_carry    = (&w_frac) & w_rbit;
  assign w_frac_rnd = w_frac + {9'd0, w_rbit};
  assign w_exp_fin  = w_carry ? w_exp_n + 7'sd1 : w_exp_n;
  assign w_ovf      = w_exp_fin >= 7'sd31;
  assign w_unf      = w_exp_fin <= 7'sd0;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state  <= IDLE;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_rem    <= '0;
      r_mb     <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_dbz    <= 1'b0;
      r_inv    <= 1'b0;
      r_inx    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_sign <= w_sign;
            if (w_special) begin
              r_done   <= 1'b1;
              r_result <= w_spec_res;
              r_ovf    <= 1'b0;
              r_unf    <= 1'b0;
              r_dbz    <= w_spec_dbz;
              r_inv    <= w_spec_inv;
              r_inx    <= 1'b0;
            end else begin
              r_exp   <= w_exp_a - w_exp_b + BIAS_Q;
              r_rem   <= {1'b0, w_mant_a};
              r_mb    <= w_mant_b;
              r_q     <= '0;
              r_cnt   <= 4'd12;
              r_busy  <= 1'b1;
              r_state <= DIV;
            end
          end
        end
        DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[11:0], w_ge};
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd0) r_state <= RND;
        end
        RND: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
          r_dbz   <= 1'b0;
          r_inv   <= 1'b0;
          r_ovf   <= w_ovf;
          r_unf   <= w_unf & ~w_ovf;
          if (w_ovf) begin
            r_result <= {r_sign, POS_INF[14:0]};
            r_inx    <= 1'b1;
          end else if (w_unf) begin
            r_result <= {r_sign, 15'h0000};
            r_inx    <= 1'b1;
          end else begin
            r_result <= {r_sign, w_exp_fin[4:0], w_frac_rnd};
            r_inx    <= w_rbit | w_sticky;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
  assign bus.o_result      = r_result;
  assign bus.o_overflow    = r_ovf;
  assign bus.o_underflow   = r_unf;
  assign bus.o_div_by_zero = r_dbz;
  assign bus.o_invalid     = r_inv;
  assign bus.o_inexact     = r_inx;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Self-checking bench for fp16_div_seq: directed vectors, handshake/reset scenarios and
// random operands against an exact rational-arithmetic reference model.
module tb_fp16_div_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  fp16_div_seq_if bus ();

  fp16_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [4:0]  f;   // {overflow, underflow, div_by_zero, invalid, inexact}
    bit          sp;
  } vec_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] dut_flags();
    return {bus.o_overflow, bus.o_underflow, bus.o_div_by_zero, bus.o_invalid, bus.o_inexact};
  endfunction

  // Reference: exact quotient as a ratio of integers, normalized into [1,2), rounded half-up.
  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] res, output logic [4:0] fl,
                                  output bit spec);
    int     ea, eb, fa, fb, e;
    bit     s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    longint num, den, sig, rem;
    ea = int'(a[14:10]); fa = int'(a[9:0]);
    eb = int'(b[14:10]); fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    nan_a  = (ea == 31) && (fa != 0);  nan_b  = (eb == 31) && (fb != 0);
    inf_a  = (ea == 31) && (fa == 0);  inf_b  = (eb == 31) && (fb == 0);
    zero_a = (ea == 0) && (fa == 0);   zero_b = (eb == 0) && (fb == 0);
    fl   = 5'b00000;
    spec = 1'b1;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      res = 16'h7E00; fl = 5'b00010;
    end else if (inf_a) begin
      res = {s, 15'h7C00};
    end else if (zero_b) begin
      res = {s, 15'h7C00}; fl = 5'b00100;
    end else if (zero_a || inf_b) begin
      res = {s, 15'h0000};
    end else begin
      spec = 1'b0;
      num = (ea == 0) ? longint'(fa) : longint'(1024 + fa);
      den = (eb == 0) ? longint'(fb) : longint'(1024 + fb);
      e   = ((ea == 0) ? 1 : ea) - ((eb == 0) ? 1 : eb);
      while (num < den) begin num = num * 2; e--; end
      while (num >= 2 * den) begin den = den * 2; e++; end
      sig = (num * 1024) / den;
      rem = (num * 1024) % den;
      if (2 * rem >= den) sig++;
      if (sig == 2048) begin sig = 1024; e++; end
      e = e + 15;
      if (e >= 31) begin
        res = {s, 15'h7C00}; fl = 5'b10001;
      end else if (e <= 0) begin
        res = {s, 15'h0000}; fl = 5'b01001;
      end else begin
        res = {s, 5'(e), 10'(sig)};
        fl  = {4'b0000, rem != 0};
      end
    end
  endfunction

  // Issues a/b in the current cycle (cycle 0) and follows it to done; returns in the done cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [4:0] ef, input bit sp,
                        input bit noise, input string tag);
    int cyc, done_cyc, lat, extra;
    bit busy_ok;
    lat      = sp ? 1 : 15;
    cyc      = 0;
    done_cyc = -1;
    busy_ok  = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_start = 1'b1;
    while (done_cyc < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      bus.i_start = noise && (cyc == 3 || cyc == 8);
      if (noise) begin bus.i_a = 16'h0000; bus.i_b = 16'h0000; end
      if (bus.o_busy !== (!sp && cyc <= 14)) busy_ok = 1'b0;
      if (bus.o_done === 1'b1) done_cyc = cyc;
    end
    bus.i_start = 1'b0;
    check({tag, " done_cycle"}, done_cyc, lat);
    check({tag, " busy_profile"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " result"}, {16'd0, bus.o_result}, {16'd0, er});
    check({tag, " flags"}, {27'd0, dut_flags()}, {27'd0, ef});
    if (noise) begin
      extra = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (bus.o_done === 1'b1) extra++;
      end
      check({tag, " extra_done"}, extra, 0);
      check({tag, " result_held"}, {16'd0, bus.o_result}, {16'd0, er});
    end
  endtask

  task automatic run_rand(input logic [15:0] a, input logic [15:0] b, input bit noise);
    logic [15:0] er;
    logic [4:0]  ef;
    bit          sp;
    ref_div(a, b, er, ef, sp);
    run_op(a, b, er, ef, sp, noise, $sformatf("rand %04h/%04h", a, b));
  endtask

  vec_t dir[16];

  initial begin
    dir[0]  = '{16'h3C00, 16'h3C00, 16'h3C00, 5'b00000, 1'b0};
    dir[1]  = '{16'h4600, 16'h4000, 16'h4200, 5'b00000, 1'b0};
    dir[2]  = '{16'h3C00, 16'h4200, 16'h3555, 5'b00001, 1'b0};
    dir[3]  = '{16'hC000, 16'h4000, 16'hBC00, 5'b00000, 1'b0};
    dir[4]  = '{16'h4000, 16'h0000, 16'h7C00, 5'b00100, 1'b1};
    dir[5]  = '{16'h0000, 16'h0000, 16'h7E00, 5'b00010, 1'b1};
    dir[6]  = '{16'h7C00, 16'h7C00, 16'h7E00, 5'b00010, 1'b1};
    dir[7]  = '{16'h7BFF, 16'h0001, 16'h7C00, 5'b10001, 1'b0};
    dir[8]  = '{16'h0400, 16'h4800, 16'h0000, 5'b01001, 1'b0};
    dir[9]  = '{16'h0200, 16'h3800, 16'h0400, 5'b00000, 1'b0};
    dir[10] = '{16'hFC00, 16'h4000, 16'hFC00, 5'b00000, 1'b1};
    dir[11] = '{16'h0000, 16'hC000, 16'h8000, 5'b00000, 1'b1};
    dir[12] = '{16'h3C00, 16'h7C00, 16'h0000, 5'b00000, 1'b1};
    dir[13] = '{16'h7E01, 16'h3C00, 16'h7E00, 5'b00010, 1'b1};
    dir[14] = '{16'hC000, 16'h8000, 16'h7C00, 5'b00100, 1'b1};
    dir[15] = '{16'h4000, 16'hC200, 16'hB955, 5'b00001, 1'b0};
  end

  initial begin
    int idle_done;
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a     = 16'h0000;
    bus.i_b     = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {13'd0, bus.o_busy, bus.o_done, dut_flags(), bus.o_result}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Consecutive directed ops are issued back-to-back in each other's done cycle.
    for (int i = 0; i < 16; i++) begin
      run_op(dir[i].a, dir[i].b, dir[i].r, dir[i].f, dir[i].sp, 1'b0,
             $sformatf("dir%0d %04h/%04h", i, dir[i].a, dir[i].b));
    end

    run_op(16'h4600, 16'h4000, 16'h4200, 5'b00000, 1'b0, 1'b1, "ignored_starts");

    // Abort a divide in cycle 7 with an asynchronous reset.
    bus.i_a = 16'h4600; bus.i_b = 16'h4000; bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("busy before abort", {31'd0, bus.o_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort outputs", {13'd0, bus.o_busy, bus.o_done, dut_flags(), bus.o_result}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.o_done === 1'b1) idle_done++;
    end
    check("no done after abort", idle_done, 0);
    run_op(16'h4600, 16'h4000, 16'h4200, 5'b00000, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 150; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 6))
        0: rb[14:10] = 5'd0;
        1: ra[14:10] = 5'd0;
        2: rb[14:10] = ra[14:10];
        3: ra[14:10] = 5'($urandom_range(0, 3));
        4: begin ra[14:10] = 5'($urandom_range(27, 30)); rb[14:10] = 5'($urandom_range(0, 3)); end
        default: ;
      endcase
      run_rand(ra, rb, (i % 25) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
